// File: rtl/scan_sel_pkg.sv
// Shared definitions for the keyboard/display scan blocks: width helper and
// anode polarity handling.
package scan_sel_pkg;

    typedef enum logic {
        AN_ACTIVE_HIGH = 1'b0,
        AN_ACTIVE_LOW  = 1'b1
    } an_pol_e;

    localparam logic AN_POL_LOW  = 1'b1;
    localparam logic AN_POL_HIGH = 1'b0;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic an_level(input logic act, input logic an_low);
        return an_low ? ~act : act;
    endfunction

endpackage

// File: rtl/scan_sel_next.sv
// Combinational search for the next enabled digit above s, modulo NDIG.
module scan_next
    import scan_sel_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int SW   = clog2_w(NDIG)
) (
    input  logic [SW-1:0]   s,
    input  logic [NDIG-1:0] mask,
    output logic [SW-1:0]   nxt,
    output logic            wrap,
    output logic            any
);

    logic [SW-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest wins;
    // k = NDIG lands back on s itself for a single-bit mask.
    always_comb begin
        nxt   = s;
        w_idx = '0;
        for (int k = NDIG; k >= 1; k--) begin
            w_idx = SW'((int'(s) + k) % NDIG);
            if (mask[w_idx]) nxt = w_idx;
        end
    end

    assign any  = |mask;
    assign wrap = (nxt <= s);

endmodule

// File: rtl/scan_sel.sv
// Multiplexed display digit scanner: prescaled slot timer, masked digit
// advance, anti-ghost blanking and one-hot anode decode.
module scan_sel
    import scan_sel_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int PRESC  = 50000,
    parameter int BLANK  = 2,
    parameter int AN_LOW = 1,
    parameter int SW     = clog2_w(NDIG)
) (
    input  logic            ck2,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NDIG-1:0] mask,
    output logic [SW-1:0]   s,
    output logic [NDIG-1:0] an,
    output logic            tick,
    output logic            frame
);

    localparam int PW = clog2_w(PRESC);
    localparam int BW = clog2_w(BLANK + 1);

    logic [PW-1:0]   r_pc;
    logic [SW-1:0]   r_s;
    logic [BW-1:0]   r_bc;
    logic            r_tick;
    logic            r_frame;
    logic [SW-1:0]   w_nxt;
    logic            w_wrap;
    logic            w_any;
    logic            w_pc_end;
    logic [NDIG-1:0] w_act;

    scan_next #(
        .NDIG (NDIG),
        .SW   (SW)
    ) u_next (
        .s    (r_s),
        .mask (mask),
        .nxt  (w_nxt),
        .wrap (w_wrap),
        .any  (w_any)
    );

    assign w_pc_end = (r_pc == PW'(PRESC - 1));

    always_ff @(posedge ck2 or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_s     <= '0;
            r_bc    <= BW'(BLANK);
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
            if (en) begin
                r_pc <= w_pc_end ? '0 : r_pc + 1'b1;
                // An empty mask lets the slot timer wrap but never advances.
                if (w_pc_end && w_any) begin
                    r_s     <= w_nxt;
                    r_bc    <= BW'(BLANK);
                    r_tick  <= 1'b1;
                    r_frame <= w_wrap;
                end else if (r_bc != '0) begin
                    r_bc <= r_bc - 1'b1;
                end
            end
        end
    end

    // rst_n gates the decode so anodes are dark during reset even with BLANK=0.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_an
        assign w_act[gi] = rst_n && (r_bc == '0) && mask[gi] && (r_s == SW'(gi));
        assign an[gi]    = an_level(w_act[gi], AN_LOW != 0);
    end

    assign s     = r_s;
    assign tick  = r_tick & en;
    assign frame = r_frame & en;

endmodule

// File: tb/tb_scan_sel.sv
// Directed bench for scan_sel: a 4-digit PRESC=4/BLANK=1 active-low instance
// and a 5-digit PRESC=1/BLANK=0 active-high instance.
module tb_scan_sel;

    logic       ck2;
    logic       rst4_n, en4;
    logic [3:0] mask4;
    logic [1:0] s4;
    logic [3:0] an4;
    logic       tick4, frame4;

    logic       rst5_n, en5;
    logic [4:0] mask5;
    logic [2:0] s5;
    logic [4:0] an5;
    logic       tick5, frame5;

    int n_vec = 0;
    int n_bad = 0;

    scan_sel #(.NDIG(4), .PRESC(4), .BLANK(1), .AN_LOW(1)) dut4 (
        .ck2(ck2), .rst_n(rst4_n), .en(en4), .mask(mask4),
        .s(s4), .an(an4), .tick(tick4), .frame(frame4)
    );

    scan_sel #(.NDIG(5), .PRESC(1), .BLANK(0), .AN_LOW(0)) dut5 (
        .ck2(ck2), .rst_n(rst5_n), .en(en5), .mask(mask5),
        .s(s5), .an(an5), .tick(tick5), .frame(frame5)
    );

    initial ck2 = 1'b0;
    always #5 ck2 = ~ck2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge ck2);
    endtask

    // Full-mask run, one entry per clock after reset release.
    logic [1:0] full_s  [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    logic [3:0] full_an [16] = '{4'he, 4'he, 4'he, 4'hf, 4'hd, 4'hd, 4'hd, 4'hf,
                                 4'hb, 4'hb, 4'hb, 4'hf, 4'h7, 4'h7, 4'h7, 4'hf};
    logic       full_t  [16] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    logic       full_f  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        int bad_cnt;
        rst4_n = 1'b0; en4 = 1'b1; mask4 = 4'b1111;
        rst5_n = 1'b0; en5 = 1'b1; mask5 = 5'b11111;

        #2;
        check("rst_s",     32'(s4), 32'd0);
        check("rst_an",    32'(an4), 32'hf);
        check("rst_tick",  32'(tick4), 32'd0);
        check("rst_frame", 32'(frame4), 32'd0);
        check("rst5_an",   32'(an5), 32'd0);
        check("rst5_s",    32'(s5), 32'd0);

        @(negedge ck2);
        rst4_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge ck2);
            $display("full cyc %0d: s=%0d an=%b tick=%b frame=%b", i + 1, s4, an4, tick4, frame4);
            check($sformatf("full_s%0d", i + 1),  32'(s4), 32'(full_s[i]));
            check($sformatf("full_an%0d", i + 1), 32'(an4), 32'(full_an[i]));
            check($sformatf("full_t%0d", i + 1),  32'(tick4), 32'(full_t[i]));
            check($sformatf("full_f%0d", i + 1),  32'(frame4), 32'(full_f[i]));
        end

        // Sparse mask 0101: 0 -> 2 -> 0 -> 2 -> 0
        mask4 = 4'b0101;
        wait_neg(4);
        check("sp_s20", 32'(s4), 32'd2); check("sp_t20", 32'(tick4), 32'd1); check("sp_f20", 32'(frame4), 32'd0);
        wait_neg(1);
        check("sp_an21", 32'(an4), 32'hb);
        wait_neg(3);
        check("sp_s24", 32'(s4), 32'd0); check("sp_t24", 32'(tick4), 32'd1); check("sp_f24", 32'(frame4), 32'd1);
        wait_neg(4);
        check("sp_s28", 32'(s4), 32'd2); check("sp_f28", 32'(frame4), 32'd0);
        wait_neg(4);
        check("sp_s32", 32'(s4), 32'd0); check("sp_f32", 32'(frame4), 32'd1);

        // Single bit 0100: current digit 0 goes dark, then 2 is held.
        mask4 = 4'b0100;
        wait_neg(1);
        check("one_an33", 32'(an4), 32'hf);
        wait_neg(3);
        check("one_s36", 32'(s4), 32'd2); check("one_t36", 32'(tick4), 32'd1); check("one_f36", 32'(frame4), 32'd0);
        wait_neg(1);
        check("one_an37", 32'(an4), 32'hb);
        wait_neg(3);
        check("one_s40", 32'(s4), 32'd2); check("one_t40", 32'(tick4), 32'd1); check("one_f40", 32'(frame4), 32'd1);
        wait_neg(4);
        check("one_t44", 32'(tick4), 32'd1); check("one_f44", 32'(frame4), 32'd1);

        // Mask bit drops mid-slot: anode goes dark without a clock edge.
        wait_neg(1);
        check("drop_an_before", 32'(an4), 32'hb);
        mask4 = 4'b0000;
        #1;
        check("drop_an_after", 32'(an4), 32'hf);

        // Empty mask for 20 cycles.
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ck2);
            if (tick4 !== 1'b0 || frame4 !== 1'b0 || s4 !== 2'd2 || an4 !== 4'hf) bad_cnt++;
        end
        $display("empty mask: %0d bad cycles of 20", bad_cnt);
        check("empty_bad_cycles", 32'(bad_cnt), 32'd0);

        // Slot timer wrapped at the last advance point; now pc=1.
        mask4 = 4'b1111;
        wait_neg(1);
        check("frz_pre_s", 32'(s4), 32'd2);
        en4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ck2);
            check($sformatf("frz_s%0d", i), 32'(s4), 32'd2);
            check($sformatf("frz_an%0d", i), 32'(an4), 32'hb);
            check($sformatf("frz_t%0d", i), 32'(tick4), 32'd0);
        end
        en4 = 1'b1;
        wait_neg(1);
        check("frz_rel_s", 32'(s4), 32'd2); check("frz_rel_t", 32'(tick4), 32'd0);
        wait_neg(1);
        check("frz_adv_s", 32'(s4), 32'd3); check("frz_adv_t", 32'(tick4), 32'd1);
        check("frz_adv_f", 32'(frame4), 32'd0); check("frz_adv_an", 32'(an4), 32'hf);

        // Async reset pulsed between edges while s=2.
        wait_neg(12);
        check("ar_pre_s", 32'(s4), 32'd2); check("ar_pre_t", 32'(tick4), 32'd1);
        #2 rst4_n = 1'b0;
        #1;
        check("ar_s", 32'(s4), 32'd0); check("ar_an", 32'(an4), 32'hf);
        check("ar_t", 32'(tick4), 32'd0); check("ar_f", 32'(frame4), 32'd0);
        #1 rst4_n = 1'b1;
        wait_neg(1);
        check("ar_post_s", 32'(s4), 32'd0); check("ar_post_an", 32'(an4), 32'he);
        wait_neg(3);
        check("ar_first_s", 32'(s4), 32'd1); check("ar_first_t", 32'(tick4), 32'd1);
        check("ar_first_f", 32'(frame4), 32'd0);

        // NDIG=5, PRESC=1, BLANK=0, active-high anodes.
        rst5_n = 1'b1;
        #1;
        check("n5_an0", 32'(an5), 32'h01);
        wait_neg(1);
        check("n5_s1", 32'(s5), 32'd1); check("n5_t1", 32'(tick5), 32'd1);
        check("n5_f1", 32'(frame5), 32'd0); check("n5_an1", 32'(an5), 32'h02);
        wait_neg(3);
        check("n5_s4", 32'(s5), 32'd4); check("n5_f4", 32'(frame5), 32'd0);
        wait_neg(1);
        check("n5_s5", 32'(s5), 32'd0); check("n5_t5", 32'(tick5), 32'd1);
        check("n5_f5", 32'(frame5), 32'd1); check("n5_an5", 32'(an5), 32'h01);
        en5 = 1'b0;
        wait_neg(1);
        check("n5_hold_s", 32'(s5), 32'd0); check("n5_hold_t", 32'(tick5), 32'd0);
        mask5 = 5'b10010;
        en5 = 1'b1;
        wait_neg(1);
        check("n5_sp_s", 32'(s5), 32'd1); check("n5_sp_f", 32'(frame5), 32'd0);
        wait_neg(1);
        check("n5_sp_s2", 32'(s5), 32'd4);
        wait_neg(1);
        check("n5_sp_s3", 32'(s5), 32'd1); check("n5_sp_f3", 32'(frame5), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_sel.md
SCAN_SEL -- requirements
Module: scan_sel

Interface
REQ-001 Parameter NDIG, default 4, number of display digits scanned (legal range 2..16).
REQ-002 Parameter PRESC, default 50000, ck2 cycles per digit slot (legal values: PRESC >= 1).
REQ-003 Parameter BLANK, default 2, anti-ghosting cycles with all anodes off after each advance (legal values: 0 <= BLANK < PRESC).
REQ-004 Parameter AN_LOW, default 1; 1 = anodes active-low, 0 = active-high.
REQ-005 ck2  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  scan enable; low freezes the scan.
REQ-008 mask  input  NDIG  per-digit enable; bit i = 0 means digit i is skipped and dark.
REQ-009 s  output  SW = clog2(NDIG)  selected digit index, drives the data multiplexer.
REQ-010 an  output  NDIG  one-hot anode drive, polarity per AN_LOW.
REQ-011 tick  output  1  one-cycle pulse, high in the first cycle of a new s value.
REQ-012 frame  output  1  one-cycle pulse, high with tick when the scan wraps.

Function
REQ-013 The prescaler pc SHALL count 0..PRESC-1 while en=1, then return to 0.
REQ-014 When en=1, pc=PRESC-1 and mask is nonzero, the block SHALL, on that edge, load s with the next index above s whose mask bit is 1, searching upward modulo NDIG.
REQ-015 The same edge SHALL set pc to 0, assert tick and load the blank counter bc with BLANK.
REQ-016 The search SHALL wrap at NDIG-1 to 0 for non-power-of-two NDIG; s SHALL never exceed NDIG-1.
REQ-017 frame SHALL assert together with tick when the new s is less than or equal to the old s.
REQ-018 With exactly one mask bit set, every advance SHALL keep that index and assert both tick and frame.
REQ-019 When mask is all zeros at the advance point, s SHALL hold, tick and frame SHALL stay 0, and pc SHALL still wrap.
REQ-020 bc SHALL decrement by 1 per cycle while nonzero and en=1.
REQ-021 an SHALL be a combinational decode of the registered s, bc and mask.
REQ-022 an bit s SHALL be active only when bc=0 and mask[s]=1; all other an bits SHALL be inactive.
REQ-023 If the current digit's mask bit drops mid-slot, its anode SHALL go inactive in the same cycle, and s SHALL advance at the normal slot end.
REQ-024 When en=0, pc, s and bc SHALL hold, tick and frame SHALL be 0, and an SHALL follow REQ-022.
REQ-025 With PRESC=1, the block SHALL advance every cycle that en=1.

Reset
REQ-026 While rst_n=0, outputs SHALL be: s=0, pc=0, bc=BLANK, tick=0, frame=0.
REQ-027 While rst_n=0, an SHALL be all inactive (all 1 when AN_LOW=1).
REQ-028 Reset asserted mid-slot SHALL force the REQ-026/027 values immediately, without waiting for a clock edge.
REQ-029 After rst_n deasserts, scanning SHALL start from digit 0 with the first slot beginning at pc=0.

Structure
REQ-030 A shared package/header SHALL hold the clog2 width function and the anode-polarity constants used by the keyboard/display blocks.
REQ-031 The next-enabled-index search SHALL be a separate combinational sub-module, scan_next (inputs s, mask; outputs nxt, wrap, any).
REQ-032 All registers SHALL be in scan_sel.

Verification
REQ-033 Reset: NDIG=4, PRESC=4, BLANK=1, AN_LOW=1, rst_n=0 -> s=0, an=4'b1111, tick=0, frame=0.
REQ-034 Full mask: mask=4'b1111, en=1 -> s steps 0,1,2,3,0 every 4 cycles; an=4'b1111 for 1 cycle after each tick, then one-hot low (e.g. 4'b1110 for s=0); frame high on the 3->0 step only.
REQ-035 Sparse mask: mask=4'b0101 -> s sequence 0,2,0,2; frame on each 2->0 step; mask=4'b0100 -> s=2 held, tick and frame pulse every 4 cycles.
REQ-036 Empty mask: mask=4'b0000 -> an=4'b1111, s constant, tick=0 and frame=0 for 20 cycles.
REQ-037 Freeze: en=0 at pc=2 for 5 cycles -> pc, s and an unchanged; advance occurs 1 cycle after en returns to 1.
REQ-038 Async reset: rst_n pulsed low between edges at s=2 -> s=0 and an=4'b1111 before the next ck2 edge; NDIG=5 run -> s wraps 4->0.
